// File: rtl/cam_stream_pkg.sv
// Shared types and colour constants for the OV7670-style test stream generator.
// Holds the FSM state encoding, pattern modes and the RGB565 palette.
package cam_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFRONT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_DIAG  = 2'd2,
    PAT_GRAD  = 2'd3
  } pat_mode_t;

  localparam logic [15:0] RGB_RED   = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_pattern_pixel.sv
// Combinational test-pattern source: maps the latched mode, solid colour and
// pixel coordinate to one RGB565 value.
module cam_pattern_pixel
  import cam_stream_pkg::*;
#(
  parameter int WIDTH = 176,
  parameter int XW    = 8,
  parameter int YW    = 8
) (
  input  pat_mode_t         mode_i,
  input  logic [15:0]       color_i,
  input  logic [XW-1:0]     x_i,
  input  logic [YW-1:0]     y_i,
  output logic [15:0]       rgb_o
);

  localparam int BAR_W = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;

  logic [15:0] xw;
  logic [15:0] yw;
  logic [15:0] bar_q16;
  logic [2:0]  bar_idx;

  always_comb begin
    xw      = 16'(x_i);
    yw      = 16'(y_i);
    bar_q16 = xw / 16'(BAR_W);
    bar_idx = (bar_q16 > 16'd7) ? 3'd7 : bar_q16[2:0];
    rgb_o   = 16'h0000;
    case (mode_i)
      PAT_SOLID: rgb_o = color_i;
      PAT_BARS:  rgb_o = bar_color(bar_idx);
      PAT_DIAG:  rgb_o = (xw == yw) ? RGB_RED : RGB_GREEN;
      PAT_GRAD:  rgb_o = {xw[7:3], yw[7:2], 5'h1F - xw[7:3]};
      default:   rgb_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670 transmitter emulator: PCLK = CLOCK/2, VSYNC/HREF/DATA updated on the
// falling PCLK edge so they are stable at every PCLK rise.
module cam_stream_gen
  import cam_stream_pkg::*;
#(
  parameter int WIDTH          = 176,
  parameter int HEIGHT         = 144,
  parameter int HBLANK         = 32,
  parameter int VSYNC_LINES    = 3,
  parameter int VBACK_LINES    = 17,
  parameter int VFRONT_LINES   = 10,
  parameter int LOW_BYTE_FIRST = 0
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic [1:0]  PATTERN,
  input  logic [15:0] COLOR,
  output logic        PCLK_OUT,
  output logic        VSYNC_OUT,
  output logic        HREF_OUT,
  output logic [7:0]  DATA_OUT,
  output logic        BUSY,
  output logic        FRAME_DONE
);

  localparam int LINE  = 2 * WIDTH + HBLANK;
  localparam int MAXL0 = (VSYNC_LINES > VBACK_LINES) ? VSYNC_LINES : VBACK_LINES;
  localparam int MAXL  = (MAXL0 > VFRONT_LINES) ? MAXL0 : VFRONT_LINES;
  localparam int XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int TW    = $clog2(LINE);
  localparam int LW    = $clog2(MAXL + 1);
  localparam logic LBF = (LOW_BYTE_FIRST != 0);

  state_t        state_q;
  pat_mode_t     mode_q;
  logic [15:0]   color_q;
  logic          pclk_q;
  logic          vsync_q;
  logic          href_q;
  logic [7:0]    data_q;
  logic          busy_q;
  logic          done_q;
  logic [XW-1:0] x_q;
  logic          half_q;
  logic [YW-1:0] y_q;
  logic [TW-1:0] tcnt_q;
  logic [LW-1:0] lcnt_q;

  logic [XW-1:0] pix_x_d;
  logic [YW-1:0] pix_y_d;
  logic          phase_d;
  logic [15:0]   rgb_d;
  logic [7:0]    byte_d;
  logic          tick;
  logic          line_end;
  logic          last_line;

  // The pattern is evaluated for the byte that will be shown after this tick,
  // so the registered DATA_OUT lines up with HREF.
  always_comb begin
    pix_x_d = '0;
    pix_y_d = y_q;
    phase_d = 1'b0;
    if (state_q == ST_ACTIVE) begin
      pix_x_d = half_q ? XW'(x_q + 1'b1) : x_q;
      phase_d = ~half_q;
    end else if (state_q == ST_HBLANK) begin
      pix_y_d = YW'(y_q + 1'b1);
    end
  end

  cam_pattern_pixel #(
    .WIDTH (WIDTH),
    .XW    (XW),
    .YW    (YW)
  ) u_pixel (
    .mode_i  (mode_q),
    .color_i (color_q),
    .x_i     (pix_x_d),
    .y_i     (pix_y_d),
    .rgb_o   (rgb_d)
  );

  assign byte_d    = (phase_d ^ LBF) ? rgb_d[7:0] : rgb_d[15:8];
  assign tick      = pclk_q;
  assign line_end  = (tcnt_q == TW'(LINE - 1));
  assign last_line = (state_q == ST_VSYNC  && lcnt_q == LW'(VSYNC_LINES - 1)) ||
                     (state_q == ST_VBACK  && lcnt_q == LW'(VBACK_LINES - 1)) ||
                     (state_q == ST_VFRONT && lcnt_q == LW'(VFRONT_LINES - 1));

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      mode_q  <= PAT_SOLID;
      color_q <= '0;
      pclk_q  <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      half_q  <= 1'b0;
      y_q     <= '0;
      tcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      pclk_q <= ~pclk_q;
      done_q <= 1'b0;
      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            if (ENABLE) begin
              mode_q  <= pat_mode_t'(PATTERN);
              color_q <= COLOR;
              busy_q  <= 1'b1;
              vsync_q <= 1'b1;
              tcnt_q  <= '0;
              lcnt_q  <= '0;
              state_q <= ST_VSYNC;
            end
          end
          ST_VSYNC, ST_VBACK, ST_VFRONT: begin
            tcnt_q <= line_end ? '0 : TW'(tcnt_q + 1'b1);
            if (line_end) begin
              lcnt_q <= last_line ? '0 : LW'(lcnt_q + 1'b1);
              if (last_line) begin
                case (state_q)
                  ST_VSYNC: begin
                    vsync_q <= 1'b0;
                    state_q <= ST_VBACK;
                  end
                  ST_VBACK: begin
                    href_q  <= 1'b1;
                    data_q  <= byte_d;
                    x_q     <= '0;
                    half_q  <= 1'b0;
                    y_q     <= '0;
                    state_q <= ST_ACTIVE;
                  end
                  default: begin
                    done_q <= 1'b1;
                    if (ENABLE) begin
                      mode_q  <= pat_mode_t'(PATTERN);
                      color_q <= COLOR;
                      vsync_q <= 1'b1;
                      state_q <= ST_VSYNC;
                    end else begin
                      busy_q  <= 1'b0;
                      state_q <= ST_IDLE;
                    end
                  end
                endcase
              end
            end
          end
          ST_ACTIVE: begin
            if (half_q && x_q == XW'(WIDTH - 1)) begin
              href_q  <= 1'b0;
              data_q  <= '0;
              half_q  <= 1'b0;
              tcnt_q  <= '0;
              state_q <= ST_HBLANK;
            end else begin
              data_q <= byte_d;
              half_q <= ~half_q;
              if (half_q) x_q <= XW'(x_q + 1'b1);
            end
          end
          ST_HBLANK: begin
            tcnt_q <= TW'(tcnt_q + 1'b1);
            if (tcnt_q == TW'(HBLANK - 1)) begin
              tcnt_q <= '0;
              if (y_q == YW'(HEIGHT - 1)) begin
                y_q     <= '0;
                lcnt_q  <= '0;
                state_q <= ST_VFRONT;
              end else begin
                y_q     <= YW'(y_q + 1'b1);
                href_q  <= 1'b1;
                data_q  <= byte_d;
                x_q     <= '0;
                half_q  <= 1'b0;
                state_q <= ST_ACTIVE;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign PCLK_OUT   = pclk_q;
  assign VSYNC_OUT  = vsync_q;
  assign HREF_OUT   = href_q;
  assign DATA_OUT   = data_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;

endmodule

// File: doc/cam_stream_gen.md
Name: cam_stream_gen

Overview:
Emulates the OV7670 parallel output for bench and on-board bring-up, so the camera downsampler and M9K path can be driven without a camera. It generates the transmitter side of the interface: PCLK, VSYNC, HREF and an 8-bit RGB565 byte stream at QCIF (176x144) from a selectable test pattern. Its outputs connect in place of the camera pins on GPIO_1_D (data on [15:8], HREF, VSYNC, PCLK).

Parameters:
WIDTH, 176, active pixels per line
HEIGHT, 144, active lines per frame
HBLANK, 32, PCLK periods with HREF low after each active line
VSYNC_LINES, 3, line periods with VSYNC high
VBACK_LINES, 17, blank line periods after VSYNC falls, before the first active line
VFRONT_LINES, 10, blank line periods after the last active line
LOW_BYTE_FIRST, 0, 0 sends {R,G[5:3]} then {G[2:0],B}; 1 sends the bytes in reverse order

Ports:
CLOCK  input  1  system clock; PCLK_OUT = CLOCK/2
RESET_N  input  1  asynchronous, active-low reset
ENABLE  input  1  while high, frames are generated back-to-back
PATTERN  input  2  0 solid, 1 colour bars, 2 diagonal, 3 gradient
COLOR  input  16  RGB565 value for the solid pattern
PCLK_OUT  output  1  pixel clock to the receiver
VSYNC_OUT  output  1  frame sync, active high
HREF_OUT  output  1  line valid, active high
DATA_OUT  output  8  pixel byte
BUSY  output  1  high from frame start through the last VFRONT line
FRAME_DONE  output  1  one-CLOCK pulse when a frame completes

Behaviour:
Reset
- Interface is single clock. RESET_N is asynchronous and active-low.
- While RESET_N is low, all outputs are 0 and the FSM is in IDLE.

Pixel clock and update timing
- PCLK_OUT toggles every CLOCK cycle.
- A tick is a cycle in which PCLK_OUT is 1, so PCLK_OUT falls on that edge.
- VSYNC_OUT, HREF_OUT and DATA_OUT change only on ticks. They are therefore stable across every PCLK_OUT rising edge.

Timing units
- LINE = 2*WIDTH + HBLANK ticks.
- All line counts below are measured in LINEs.

FSM: IDLE -> VSYNC -> VBACK -> ACTIVE <-> HBLANK -> VFRONT -> IDLE or VSYNC
- IDLE: all signals low. On a tick with ENABLE=1, latch PATTERN and COLOR, assert BUSY, and go to VSYNC.
- VSYNC: VSYNC_OUT=1 for VSYNC_LINES*LINE ticks.
- VBACK: VSYNC_OUT=0, HREF_OUT=0 for VBACK_LINES*LINE ticks.
- ACTIVE: HREF_OUT=1 for exactly 2*WIDTH ticks. Pixel x is emitted over ticks 2x and 2x+1, with byte order set by LOW_BYTE_FIRST.
- HBLANK: HREF_OUT=0 and DATA_OUT=0 for HBLANK ticks. Then y increments.
  - If y < HEIGHT, return to ACTIVE.
  - Otherwise go to VFRONT.
- VFRONT: lasts VFRONT_LINES*LINE ticks. On its last tick:
  - pulse FRAME_DONE;
  - if ENABLE=1, relatch PATTERN/COLOR and go directly to VSYNC, keeping BUSY high;
  - otherwise clear BUSY and go to IDLE.

Mid-frame inputs
- ENABLE falling mid-frame does not truncate the frame. The current frame always completes.
- PATTERN and COLOR changes mid-frame are ignored until the next frame latch.

Counters and reset mid-frame
- x counts 0..WIDTH-1, y counts 0..HEIGHT-1.
- Counters are sized with $clog2 and wrap only via explicit compare; there is no free-running overflow.
- Reset mid-frame returns to IDLE immediately. VSYNC_OUT and HREF_OUT drop asynchronously.

Patterns (RGB565, evaluated from the latched mode and the current x, y)
- 0 solid: COLOR.
- 1 bars: bar index = x/(WIDTH/8), clamped to 7. Colours in order:
  - FFFF, FFE0, 07FF, 07E0
  - F81F, F800, 001F, 0000
- 2 diagonal: x==y gives F800, otherwise 07E0.
- 3 gradient: R = x[7:3], G = y[7:2], B = 5'h1F - x[7:3], each truncated to its field width.

Decomposition:
- Package cam_stream_pkg holds:
  - state encoding (IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT);
  - pattern mode constants;
  - the eight RGB565 bar colours;
  - RED/GREEN RGB565 constants.
- One sub-module, cam_pattern_pixel, is combinational: latched mode, colour, x and y in, RGB565 out.
- Byte select and output registers stay in cam_stream_gen.

Test Plan:
- Timing (defaults): ENABLE=1, PATTERN=0, COLOR=16'hF800.
  - Per line, HREF high for exactly 352 PCLK rises.
  - Per frame, 144 HREF pulses.
  - VSYNC high for 3*384 PCLK periods.
  - FRAME_DONE every 174*384*2 CLOCK cycles.
- Byte order, solid: COLOR=16'h07E0, LOW_BYTE_FIRST=0 -> bytes 8'h07, 8'hE0 alternate. LOW_BYTE_FIRST=1 -> 8'hE0, 8'h07.
- Colour bars: PATTERN=1, check x=21 -> FFFF and x=22 -> FFE0 (bytes FF,E0). Check x=175 -> 0000.
- Enable and mode handling:
  - Drop ENABLE at y=50 -> the frame completes to 144 lines, FRAME_DONE pulses, then BUSY=0 and VSYNC stays low.
  - Change PATTERN mid-frame -> no effect until the next frame.
- Reset mid-frame: assert RESET_N low at y=10, x=40 -> all outputs 0 within the same CLOCK. After release with ENABLE=1 -> a new frame starts with a full VSYNC.
- Loopback through the camera downsampler, PATTERN=2:
  - M9K address y*176+y holds the RGB332 of F800 (8'hE0).
  - All other addresses hold the RGB332 of 07E0 (8'h1C).
